// File: rtl/obstacle_pkg.sv
// obstacle_pkg: shared obstacle types, bus field layout, lane entry format
// and the LFSR step used for row generation.
package obstacle_pkg;

  typedef enum logic [2:0] {
    OBS_EMPTY = 3'b000,
    OBS_LOW   = 3'b001,
    OBS_HIGH  = 3'b010,
    OBS_MID   = 3'b011,
    OBS_TRAIN = 3'b100,
    OBS_RAMP  = 3'b101
  } obs_type_e;

  // Obstacle word layout: [15:13] type, [12:11] lane, [10:0] depth
  localparam int TYPE_MSB  = 15;
  localparam int TYPE_LSB  = 13;
  localparam int LANE_MSB  = 12;
  localparam int LANE_LSB  = 11;
  localparam int DEPTH_MSB = 10;
  localparam int DEPTH_LSB = 0;

  // The first half of a ramp is reported one ring-length further away
  localparam int RAMP_FIRST_OFFSET = 256;

  localparam int          NUM_LANES    = 3;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // ramp_half: 0 = first (low) half, 1 = second half
  typedef struct packed {
    logic      ramp_half;
    obs_type_e kind;
  } lane_entry_t;

  typedef lane_entry_t [NUM_LANES-1:0] row_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } stream_state_e;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting towards the MSB
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/obstacle_row_gen.sv
// obstacle_row_gen: LFSR-driven generator for one new track row.
// The row is combinational from the current LFSR state and the previous
// last row; the LFSR steps only when the row is consumed (step_i).
// Optional feature macro: OBSTACLE_TRAINS_EN (draw 7 with lfsr[9]=0 gives a
// train when defined, an empty lane otherwise).
module obstacle_row_gen
  import obstacle_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step_i,
  input  row_t prev_row_i,
  output row_t row_o
);

  // An all-zero seed would lock the LFSR, so it falls back to the default
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  row_t        forced;
  logic [2:0]  open;
  logic [1:0]  block_lane;

  // Map a 3-bit draw to a lane entry, then complete any pending ramp
  function automatic lane_entry_t gen_lane(input logic [2:0]  draw,
                                           input logic        ramp_sel,
                                           input lane_entry_t prev);
    lane_entry_t e;
    e.ramp_half = 1'b0;
    case (draw)
      3'd4: e.kind = OBS_LOW;
      3'd5: e.kind = OBS_HIGH;
      3'd6: e.kind = OBS_MID;
      3'd7: begin
        if (ramp_sel) begin
          e.kind = OBS_RAMP;
        end else begin
`ifdef OBSTACLE_TRAINS_EN
          e.kind = OBS_TRAIN;
`else
          e.kind = OBS_EMPTY;
`endif
        end
      end
      default: e.kind = OBS_EMPTY;
    endcase
    if (prev.kind == OBS_RAMP && !prev.ramp_half) begin
      e.kind      = OBS_RAMP;
      e.ramp_half = 1'b1;
    end
    return e;
  endfunction

  assign lfsr_d = step_i ? lfsr_next(lfsr_q) : lfsr_q;

  // LFSR state register, stepped once per generated row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED_EFF;
    else        lfsr_q <= lfsr_d;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign forced[l] = gen_lane(lfsr_q[3*l +: 3], lfsr_q[9], prev_row_i[l]);
    // A lane is passable when empty or when it is the landing half of a ramp
    assign open[l]   = (forced[l].kind == OBS_EMPTY) || forced[l].ramp_half;
  end

  assign block_lane = (lfsr_q[15:14] == 2'd3) ? 2'd0 : lfsr_q[15:14];

  // Clear one lane if the drawn row would wall off every lane
  always_comb begin
    row_o = forced;
    if (~|open) row_o[block_lane] = '{ramp_half: 1'b0, kind: OBS_EMPTY};
  end

endmodule

// File: rtl/obstacle_streamer.sv
// obstacle_streamer: keeps a ring of upcoming rows, adds a row at every
// half-block boundary and replays all rows as a burst of obstacle words
// after each frame strobe. Optional feature macro: OBSTACLE_TRAINS_EN
// (handled inside obstacle_row_gen).
module obstacle_streamer
  import obstacle_pkg::*;
#(
  parameter int          HALF_BLOCK_LENGTH = 64,
  parameter int          SPEED             = 1,
  parameter int          NUM_ROWS          = 4,
  parameter logic [15:0] SEED              = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        new_frame,
  input  logic        game_over,
  output logic [15:0] obstacle,
  output logic        obstacle_valid,
  output logic        firstrow,
  output logic        stream_done
);

  localparam int PROG_W = 8;
  localparam int HEAD_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int RC_W   = $clog2(NUM_ROWS + 1);

  logic [PROG_W-1:0] progress_q, progress_d;
  logic [HEAD_W-1:0] head_q, head_d, prev_idx;
  row_t              ring_q [NUM_ROWS];
  row_t              ring_d [NUM_ROWS];
  row_t              gen_row;
  logic              gen_step;

  stream_state_e     state_q, state_d;
  logic [RC_W-1:0]   rc_q, rc_d, rc_sel;
  logic [1:0]        lc_q, lc_d, lc_sel;
  logic              emit, done_d;

  logic [HEAD_W:0]   ridx;
  lane_entry_t       entry;
  logic [10:0]       depth;
  logic [15:0]       word_d;

  logic [15:0]       obstacle_q;
  logic              vld_q, first_q, done_q;

  assign prev_idx = (head_q == '0) ? HEAD_W'(NUM_ROWS - 1) : head_q - HEAD_W'(1);

  obstacle_row_gen #(.SEED(SEED)) u_row_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_i    (gen_step),
    .prev_row_i(ring_q[prev_idx]),
    .row_o     (gen_row)
  );

  // Progress/ring next state: advance on a live frame, shift at the boundary
  always_comb begin
    progress_d = progress_q;
    head_d     = head_q;
    ring_d     = ring_q;
    gen_step   = 1'b0;
    if (new_frame && !game_over) begin
      if (progress_q < PROG_W'(HALF_BLOCK_LENGTH - SPEED)) begin
        progress_d = progress_q + PROG_W'(SPEED);
      end else begin
        progress_d     = '0;
        head_d         = (head_q == HEAD_W'(NUM_ROWS - 1)) ? '0 : head_q + HEAD_W'(1);
        ring_d[head_q] = gen_row;
        gen_step       = 1'b1;
      end
    end
  end

  // Progress, head and ring storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      progress_q <= '0;
      head_q     <= '0;
      for (int i = 0; i < NUM_ROWS; i++) ring_q[i] <= '0;
    end else begin
      progress_q <= progress_d;
      head_q     <= head_d;
      ring_q     <= ring_d;
    end
  end

  // Burst state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rc_q    <= '0;
      lc_q    <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      lc_q    <= lc_d;
    end
  end

  // Burst sequencing: a frame strobe always restarts at row 0 lane 0
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    lc_d    = lc_q;
    rc_sel  = rc_q;
    lc_sel  = lc_q;
    emit    = 1'b0;
    done_d  = 1'b0;
    if (new_frame) begin
      state_d = ST_STREAM;
      emit    = 1'b1;
      rc_sel  = '0;
      lc_sel  = '0;
      rc_d    = '0;
      lc_d    = 2'd1;
    end else if (state_q == ST_STREAM) begin
      if (rc_q == RC_W'(NUM_ROWS)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        emit = 1'b1;
        if (lc_q == 2'd2) begin
          lc_d = 2'd0;
          rc_d = rc_q + RC_W'(1);
        end else begin
          lc_d = lc_q + 2'd1;
        end
      end
    end
  end

  // Word assembly from post-update state so the first word already sees it
  always_comb begin
    ridx = {1'b0, head_d} + (HEAD_W+1)'(rc_sel);
    if (ridx >= (HEAD_W+1)'(NUM_ROWS)) ridx = ridx - (HEAD_W+1)'(NUM_ROWS);
    entry = ring_d[ridx[HEAD_W-1:0]][lc_sel];
    depth = (11'(rc_sel) + 11'd1) * 11'(HALF_BLOCK_LENGTH) - 11'(progress_d) - 11'd1;
    if (entry.kind == OBS_RAMP && !entry.ramp_half) depth = depth + 11'(RAMP_FIRST_OFFSET);
    word_d                      = '0;
    word_d[TYPE_MSB:TYPE_LSB]   = entry.kind;
    word_d[LANE_MSB:LANE_LSB]   = lc_sel;
    word_d[DEPTH_MSB:DEPTH_LSB] = depth;
  end

  // Registered outputs; word and firstrow read as zero outside valid cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obstacle_q <= '0;
      vld_q      <= 1'b0;
      first_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      obstacle_q <= emit ? word_d : '0;
      vld_q      <= emit;
      first_q    <= emit && (rc_sel == '0);
      done_q     <= done_d;
    end
  end

  assign obstacle       = obstacle_q;
  assign obstacle_valid = vld_q;
  assign firstrow       = first_q;
  assign stream_done    = done_q;

endmodule

// File: tb/tb_obstacle_streamer.sv
// tb_obstacle_streamer: randomized frame stimulus checked against a
// row-list reference model of the obstacle streamer.
module tb_obstacle_streamer;

  localparam int HBL = 64;
  localparam int SPD = 1;
  localparam int NR  = 4;
  localparam int NW  = 3 * NR;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_frame = 1'b0;
  logic        game_over = 1'b0;
  logic [15:0] obstacle;
  logic        obstacle_valid;
  logic        firstrow;
  logic        stream_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: rows listed nearest first, no ring pointer
  int          m_type [NR][3];
  int          m_half [NR][3];
  int          m_prog;
  logic [15:0] m_lfsr;
  int          rows_made = 0;
  int          blocked_seen = 0;
  int          ramp2_seen = 0;

  // Captured burst: {valid, firstrow, stream_done, obstacle}
  logic [18:0] cap [NW+1];

  obstacle_streamer #(
    .HALF_BLOCK_LENGTH(HBL),
    .SPEED            (SPD),
    .NUM_ROWS         (NR),
    .SEED             (16'hACE1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .new_frame     (new_frame),
    .game_over     (game_over),
    .obstacle      (obstacle),
    .obstacle_valid(obstacle_valid),
    .firstrow      (firstrow),
    .stream_done   (stream_done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++)
      for (int l = 0; l < 3; l++) begin
        m_type[r][l] = 0;
        m_half[r][l] = 0;
      end
    m_prog = 0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_frame(input bit frozen);
    int  nt [3];
    int  nh [3];
    int  draw;
    int  bl;
    bit  open;
    if (frozen) return;
    if (m_prog < HBL - SPD) begin
      m_prog += SPD;
      return;
    end
    m_prog = 0;
    open   = 0;
    for (int l = 0; l < 3; l++) begin
      draw  = int'((m_lfsr >> (3 * l)) & 16'h7);
      nh[l] = 0;
      if (m_type[NR-1][l] == 5 && m_half[NR-1][l] == 0) begin
        nt[l] = 5;
        nh[l] = 1;
        ramp2_seen++;
      end else if (draw < 4) nt[l] = 0;
      else if (draw < 7)     nt[l] = draw - 3;
      else if (m_lfsr[9])    nt[l] = 5;
      else begin
`ifdef OBSTACLE_TRAINS_EN
        nt[l] = 4;
`else
        nt[l] = 0;
`endif
      end
      if (nt[l] == 0 || nh[l] == 1) open = 1;
    end
    if (!open) begin
      bl = int'(m_lfsr[15:14]) % 3;
      nt[bl] = 0;
      nh[bl] = 0;
      blocked_seen++;
    end
    for (int r = 0; r < NR - 1; r++)
      for (int l = 0; l < 3; l++) begin
        m_type[r][l] = m_type[r+1][l];
        m_half[r][l] = m_half[r+1][l];
      end
    for (int l = 0; l < 3; l++) begin
      m_type[NR-1][l] = nt[l];
      m_half[NR-1][l] = nh[l];
    end
    m_lfsr = lfsr_step(m_lfsr);
    rows_made++;
  endtask

  // Expected sample k of a burst (k == NW is the stream_done cycle)
  function automatic logic [18:0] exp_sample(input int k);
    int r, l, d;
    logic [15:0] w;
    if (k >= NW) return {3'b001, 16'h0000};
    r = k / 3;
    l = k % 3;
    d = (r + 1) * HBL - m_prog - 1;
    if (m_type[r][l] == 5 && m_half[r][l] == 0) d += 256;
    w = {m_type[r][l][2:0], l[1:0], d[10:0]};
    return {1'b1, (r == 0), 1'b0, w};
  endfunction

  // Strobe one frame and capture the burst and the following done cycle
  task automatic do_frame();
    @(negedge clk);
    new_frame = 1'b1;
    model_frame(game_over);
    @(negedge clk);
    new_frame = 1'b0;
    cap[0] = {obstacle_valid, firstrow, stream_done, obstacle};
    for (int k = 1; k <= NW; k++) begin
      @(negedge clk);
      cap[k] = {obstacle_valid, firstrow, stream_done, obstacle};
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (obstacle !== 16'h0) begin
      n_fail++; $display("FAIL reset_obstacle: got %h expected 0000", obstacle);
    end
    n_tests++;
    if (obstacle_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", obstacle_valid);
    end
    n_tests++;
    if (firstrow !== 1'b0) begin
      n_fail++; $display("FAIL reset_firstrow: got %b expected 0", firstrow);
    end
    n_tests++;
    if (stream_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b expected 0", stream_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_frame();
    game_over = 1'b0;
    do_frame();
    n_tests++;
    if (cap[0] !== {3'b110, 16'd62}) begin
      n_fail++; $display("FAIL first_word: got %h expected %h", cap[0], {3'b110, 16'd62});
    end
    for (int k = 0; k <= NW; k++) begin
      n_tests++;
      if (cap[k] !== exp_sample(k)) begin
        n_fail++; $display("FAIL first_frame word %0d: got %h expected %h", k, cap[k], exp_sample(k));
      end
    end
  endtask

  task automatic test_random_run();
    int frames = 0;
    while (rows_made < 36 && frames < 3000) begin
      game_over = ($urandom_range(7) == 0);
      do_frame();
      frames++;
      for (int k = 0; k <= NW; k++) begin
        n_tests++;
        if (cap[k] !== exp_sample(k)) begin
          n_fail++;
          $display("FAIL random_run frame %0d word %0d: got %h expected %h", frames, k, cap[k], exp_sample(k));
        end
      end
    end
    game_over = 1'b0;
    $display("info: rows %0d, blocked rows %0d, ramp completions %0d", rows_made, blocked_seen, ramp2_seen);
  endtask

  task automatic test_game_over();
    game_over = 1'b1;
    for (int f = 0; f < 10; f++) begin
      do_frame();
      for (int k = 0; k <= NW; k++) begin
        n_tests++;
        if (cap[k] !== exp_sample(k)) begin
          n_fail++; $display("FAIL game_over frame %0d word %0d: got %h expected %h", f, k, cap[k], exp_sample(k));
        end
      end
    end
    game_over = 1'b0;
    do_frame();
    for (int k = 0; k <= NW; k++) begin
      n_tests++;
      if (cap[k] !== exp_sample(k)) begin
        n_fail++; $display("FAIL game_over_resume word %0d: got %h expected %h", k, cap[k], exp_sample(k));
      end
    end
  endtask

  task automatic test_abort();
    logic [18:0] got;
    game_over = 1'b0;
    @(negedge clk);
    new_frame = 1'b1;
    model_frame(1'b0);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      new_frame = 1'b0;
      got = {obstacle_valid, firstrow, stream_done, obstacle};
      n_tests++;
      if (got !== exp_sample(k)) begin
        n_fail++; $display("FAIL abort_first word %0d: got %h expected %h", k, got, exp_sample(k));
      end
    end
    new_frame = 1'b1;
    model_frame(1'b0);
    @(negedge clk);
    new_frame = 1'b0;
    for (int k = 0; k <= NW; k++) begin
      if (k > 0) @(negedge clk);
      got = {obstacle_valid, firstrow, stream_done, obstacle};
      n_tests++;
      if (got !== exp_sample(k)) begin
        n_fail++; $display("FAIL abort_restart word %0d: got %h expected %h", k, got, exp_sample(k));
      end
    end
  endtask

  task automatic test_reset_midburst();
    @(negedge clk);
    new_frame = 1'b1;
    model_frame(1'b0);
    @(negedge clk);
    new_frame = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (obstacle_valid !== 1'b1) begin
      n_fail++; $display("FAIL midburst_valid: got %b expected 1", obstacle_valid);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({obstacle_valid, firstrow, stream_done, obstacle} !== 19'h0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %h expected 00000", {obstacle_valid, firstrow, stream_done, obstacle});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_frame();
    for (int k = 0; k <= NW; k++) begin
      n_tests++;
      if (cap[k] !== exp_sample(k)) begin
        n_fail++; $display("FAIL after_reset word %0d: got %h expected %h", k, cap[k], exp_sample(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_random_run();
    test_game_over();
    test_abort();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
